// File: rtl/kyber_pkg.sv
// Shared constants, FSM state type and d-legality helper for the compress path.
package kyber_pkg;

  localparam int Q      = 3329;
  localparam int N_COEF = 256;
  localparam int AW     = $clog2(N_COEF);
  localparam int DW     = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } comp_seq_state_e;

  // Compression widths used by the ciphertext encoding.
  function automatic logic d_is_legal(input logic [4:0] d);
    return (d == 5'd1) || (d == 5'd4) || (d == 5'd5) || (d == 5'd10) || (d == 5'd11);
  endfunction

endpackage

// File: rtl/compress_module.sv
// Combinational compress: y = round(2^d * x / Q) mod 2^d, zero-extended to 11 bits.
module compress_module #(
  parameter int Q = kyber_pkg::Q
) (
  input  logic [15:0] x,
  input  logic [4:0]  d,
  output logic [10:0] y
);

  logic [31:0] scaled;
  logic [31:0] quot;
  logic [31:0] mask;

  // Rounded division: adding floor(Q/2) before dividing rounds half-up (Q is odd, so no ties).
  always_comb begin
    scaled = ({16'b0, x} << d) + 32'(Q / 2);
    quot   = scaled / 32'(Q);
    mask   = (32'd1 << d) - 32'd1;
    y      = 11'(quot & mask);
  end

endmodule

// File: rtl/compress_sequencer.sv
// Streams one polynomial from the coefficient RAM through compress_module into a
// small credit-controlled output buffer with a valid/ready interface.
module compress_sequencer
  import kyber_pkg::*;
#(
  parameter int BUF_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       d_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_rd_en,
  output logic [AW-1:0]    mem_addr,
  input  logic [15:0]      mem_rd_data,
  output logic             cmp_valid,
  input  logic             cmp_ready,
  output logic [DW-1:0]    cmp_data,
  output logic [AW-1:0]    cmp_idx
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]  DEPTH_L = (CW + 1)'(BUF_DEPTH);
  localparam logic [AW:0]  LAST_L  = (AW + 1)'(N_COEF - 1);

  comp_seq_state_e state_q, state_d;

  logic [4:0]    d_q, d_d;
  logic [AW:0]   issue_cnt_q, issue_cnt_d;
  logic [AW:0]   out_cnt_q, out_cnt_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic [DW-1:0] buf_data_q [BUF_DEPTH];
  logic [AW-1:0] buf_idx_q  [BUF_DEPTH];

  logic          start_ok;
  logic          push;
  logic          pop;
  logic [CW:0]   credit_use;
  logic [DW-1:0] cmp_word;

  compress_module #(.Q(Q)) u_compress (
    .x (mem_rd_data),
    .d (d_q),
    .y (cmp_word)
  );

  // State register.
  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && d_is_legal(d_in))        state_d = RUN;
      RUN:     if (mem_rd_en && issue_cnt_q == LAST_L) state_d = DRAIN;
      DRAIN:   if (pop && out_cnt_q == LAST_L)         state_d = FIN;
      FIN:                                             state_d = IDLE;
      default:                                         state_d = IDLE;
    endcase
  end

  // Outputs: read credit uses registered occupancy only, so a same-cycle pop is ignored.
  always_comb begin
    credit_use = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    busy       = (state_q == RUN) || (state_q == DRAIN);
    done       = (state_q == FIN);
    err        = err_q;
    mem_rd_en  = (state_q == RUN) && (credit_use < DEPTH_L);
    mem_addr   = issue_cnt_q[AW-1:0];
    cmp_valid  = (count_q != '0);
    cmp_data   = cmp_valid ? buf_data_q[rd_ptr_q] : '0;
    cmp_idx    = cmp_valid ? buf_idx_q[rd_ptr_q]  : '0;
  end

  // Datapath next values: counters, in-flight tracking and buffer pointers.
  always_comb begin
    start_ok    = (state_q == IDLE) && start && d_is_legal(d_in);
    push        = inflight_q;
    pop         = cmp_valid && cmp_ready;
    d_d         = start_ok ? d_in : d_q;
    err_d       = (state_q == IDLE) && start && !d_is_legal(d_in);
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    if (start_ok) begin
      issue_cnt_d = '0;
      out_cnt_d   = '0;
    end else begin
      if (mem_rd_en) issue_cnt_d = issue_cnt_q + (AW + 1)'(1);
      if (pop)       out_cnt_d   = out_cnt_q + (AW + 1)'(1);
    end
    inflight_d = mem_rd_en;
    rd_idx_d   = mem_rd_en ? issue_cnt_q[AW-1:0] : rd_idx_q;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Datapath registers; reset drops buffered words and any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q         <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      rd_idx_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      d_q         <= d_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= inflight_d;
      rd_idx_q    <= rd_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  // Buffer storage: compressed word and its index written when RAM data returns.
  // NOTE: storage is not reset; count_q gates validity and outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data_q[wr_ptr_q] <= cmp_word;
      buf_idx_q[wr_ptr_q]  <= rd_idx_q;
    end
  end

endmodule

// File: tb/tb_compress_sequencer.sv
// Self-checking bench: random RAM contents, real-arithmetic compress reference,
// directed steps for timing, backpressure, illegal d, restart and mid-run reset.
module tb_compress_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  d_in;
  logic        busy, done, err, mem_rd_en, cmp_valid, cmp_ready;
  logic [7:0]  mem_addr, cmp_idx;
  logic [15:0] mem_rd_data = '0;
  logic [10:0] cmp_data;

  logic [15:0] ram [256];
  logic [10:0] got [256];
  int          n_pass  = 0;
  int          n_fail  = 0;
  int          n_total = 0;

  compress_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .d_in        (d_in),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .cmp_valid   (cmp_valid),
    .cmp_ready   (cmp_ready),
    .cmp_data    (cmp_data),
    .cmp_idx     (cmp_idx)
  );

  initial forever #5 clk = ~clk;

  // Synchronous-read coefficient RAM.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

  // Reference: round(2^d * x / q) mod 2^d using real arithmetic.
  function automatic logic [10:0] ref_cmp(input logic [4:0] d, input logic [15:0] x);
    real r;
    int  v;
    r = (real'(x) * real'(1 << int'(d))) / 3329.0;
    v = int'($floor(r + 0.5));
    return 11'(v % (1 << int'(d)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {busy, done, err, mem_rd_en, cmp_valid, mem_addr, cmp_data, cmp_idx};
  endfunction

  // One polynomial: mode 0 = always ready, mode 1 = ready, 20-cycle stall, then random.
  task automatic run_poly(input logic [4:0] d, input int mode, input bit extra_start,
                          input int abort_at);
    int cyc = 0, n_hs = 0, n_rd = 0, done_cnt = 0;
    int t_rd = -1, t_val = -1, t_last = -1;
    int addr_bad = 0, credit_bad = 0, err_cnt = 0;
    bit stall_pending = 1'b0;
    logic [10:0] s_data = '0;
    logic [7:0]  s_idx = '0;
    for (int i = 0; i < 256; i++) got[i] = '0;
    start = 1'b1; d_in = d; cmp_ready = 1'b1;
    while (done_cnt == 0 && cyc < 3000) begin
      step(); cyc++;
      start = 1'b0; d_in = d;
      if (extra_start && cyc == 10) begin start = 1'b1; d_in = 5'd5; end
      if (mode == 1) cmp_ready = (cyc < 60) ? 1'b1 : (cyc < 80) ? 1'b0 : 1'($urandom_range(0, 1));
      if (cyc == 1) chk("busy_rise", 32'(busy), 32'd1);
      if (err) err_cnt++;
      if (mem_rd_en) begin
        if (mem_addr != 8'(n_rd)) addr_bad++;
        n_rd++;
        if (t_rd < 0) t_rd = cyc;
      end
      if (n_rd - n_hs > 4) credit_bad++;
      if (stall_pending) begin
        chk("stall_valid", 32'(cmp_valid), 32'd1);
        chk("stall_data", 32'(cmp_data), 32'(s_data));
        chk("stall_idx", 32'(cmp_idx), 32'(s_idx));
        stall_pending = 1'b0;
      end
      if (cmp_valid && t_val < 0) t_val = cyc;
      if (done) begin
        done_cnt++;
        chk("busy_at_done", 32'(busy), 32'd0);
      end
      if (cmp_valid && cmp_ready) begin
        if (n_hs < 256) begin
          chk("out_idx", 32'(cmp_idx), 32'(n_hs));
          chk("out_data", 32'(cmp_data), 32'(ref_cmp(d, ram[n_hs])));
          got[n_hs] = cmp_data;
        end else begin
          chk("extra_output", 32'(n_hs), 32'd255);
        end
        n_hs++;
        t_last = cyc;
        if (n_hs == abort_at) begin
          step();
          rst = 1'b1;
          step();
          chk("rst_mid_outputs", all_outs(), 32'd0);
          rst = 1'b0; cmp_ready = 1'b0; start = 1'b0;
          return;
        end
      end else if (cmp_valid) begin
        stall_pending = 1'b1; s_data = cmp_data; s_idx = cmp_idx;
      end
    end
    repeat (3) begin
      step();
      if (done) done_cnt++;
      if (cmp_valid) n_hs++;
    end
    chk("handshakes", 32'(n_hs), 32'd256);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("reads", 32'(n_rd), 32'd256);
    chk("read_order", 32'(addr_bad), 32'd0);
    chk("credit_limit", 32'(credit_bad), 32'd0);
    chk("no_err", 32'(err_cnt), 32'd0);
    if (mode == 0) begin
      chk("first_rd", 32'(t_rd), 32'd1);
      chk("first_valid", 32'(t_val), 32'd3);
      chk("last_hs", 32'(t_last), 32'd258);
    end
  endtask

  initial begin
    int rd_seen;
    rst = 1'b1; start = 1'b0; d_in = '0; cmp_ready = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom_range(0, 3328));
    repeat (3) step();
    chk("reset_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Illegal d: one err pulse, no activity.
    start = 1'b1; d_in = 5'd7;
    step();
    start = 1'b0;
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    rd_seen = 0;
    repeat (4) begin
      if (mem_rd_en || busy) rd_seen++;
      step();
      if (err) rd_seen++;
    end
    chk("err_no_activity", 32'(rd_seen), 32'd0);

    // d=1 with directed head values.
    ram[0] = 16'd0; ram[1] = 16'd832; ram[2] = 16'd833; ram[3] = 16'd2497;
    run_poly(5'd1, 0, 1'b0, -1);
    chk("d1_c0", 32'(got[0]), 32'd0);
    chk("d1_c1", 32'(got[1]), 32'd0);
    chk("d1_c2", 32'(got[2]), 32'd1);
    chk("d1_c3", 32'(got[3]), 32'd0);

    // Wide d values, with a start pulse during RUN that must be ignored.
    ram[5] = 16'd1665; ram[6] = 16'd3328; ram[7] = 16'd1000;
    run_poly(5'd10, 0, 1'b1, -1);
    chk("d10_c5", 32'(got[5]), 32'd512);
    run_poly(5'd11, 0, 1'b0, -1);
    chk("d11_c6", 32'(got[6]), 32'd2047);
    run_poly(5'd4, 0, 1'b0, -1);
    chk("d4_c7", 32'(got[7]), 32'd5);

    // Backpressure with fresh random contents.
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom_range(0, 3328));
    run_poly(5'd5, 1, 1'b0, -1);

    // Reset after output 100, then a clean restart from index 0.
    run_poly(5'd11, 1, 1'b0, 100);
    step();
    chk("post_rst_idle", 32'(busy), 32'd0);
    run_poly(5'd11, 0, 1'b0, -1);
    chk("restart_c0", 32'(got[0]), 32'(ref_cmp(5'd11, ram[0])));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
